// File: rtl/lfa_adc_pkg.sv
// ============================================================================
// Package  : lfa_adc_pkg
// Brief    : Shared types and constants for the LFA ADC128S022 reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfa_adc_pkg;

  // Logical sensor selector; the code value 3 is never used.
  typedef enum logic [1:0] {
    LEFT   = 2'd0,
    MIDDLE = 2'd1,
    RIGHT  = 2'd2
  } lfa_ch_t;

  // Top-level sequencing states.
  typedef enum logic [0:0] {
    ST_GAP  = 1'b0,
    ST_CONV = 1'b1
  } lfa_state_t;

  // SCK half-periods in one CS-low frame (16 SCK cycles).
  localparam int FRAME_PHASES = 32;
  localparam int DATA_MSB     = 11;
  localparam int DATA_LSB     = 0;

  // Scan order LEFT -> MIDDLE -> RIGHT -> LEFT.
  function automatic lfa_ch_t next_ch(input lfa_ch_t ch);
    case (ch)
      LEFT:    next_ch = MIDDLE;
      MIDDLE:  next_ch = RIGHT;
      default: next_ch = LEFT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_spi_frame.sv
// ============================================================================
// Module   : adc_spi_frame
// Brief    : One CS-low ADC128S022 frame: drives SCK/DIN (channel address)
//            and shifts in the 16-bit DOUT word, returning its 12 data bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_spi_frame
  import lfa_adc_pkg::*;
(
  input  logic                     clk_3125KHz,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               addr,
  input  logic                     adc_dout,
  output logic                     adc_sck,
  output logic                     adc_din,
  output logic                     done,
  output logic [DATA_MSB:DATA_LSB] result
);

  localparam logic [4:0] c_LAST_PHASE = 5'(FRAME_PHASES - 1);

  logic       r_active;
  logic [4:0] r_phase;
  logic [2:0] r_addr;
  // The four leading zero bits of the DOUT word simply fall off the top.
  logic [DATA_MSB:DATA_LSB] r_shift;

  logic [4:0] w_next_phase;
  logic [3:0] w_bit_idx;
  logic       w_din_next;

  assign w_next_phase = r_phase + 5'd1;
  assign w_bit_idx    = w_next_phase[4:1];

  // DIN bit for the SCK cycle being entered: ADD2..ADD0 at bits 2..4, else 0.
  always_comb begin
    w_din_next = 1'b0;
    case (w_bit_idx)
      4'd2:    w_din_next = r_addr[2];
      4'd3:    w_din_next = r_addr[1];
      4'd4:    w_din_next = r_addr[0];
      default: w_din_next = 1'b0;
    endcase
  end

  // Phase counter; SCK falls on even phases (DIN update), rises on odd (sample).
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_phase  <= 5'd0;
      r_addr   <= 3'd0;
      r_shift  <= '0;
      adc_sck  <= 1'b1;
      adc_din  <= 1'b0;
    end else if (r_active) begin
      if (r_phase == c_LAST_PHASE) begin
        r_active <= 1'b0;
        r_phase  <= 5'd0;
        adc_sck  <= 1'b1;
        adc_din  <= 1'b0;
      end else begin
        r_phase <= w_next_phase;
        adc_sck <= w_next_phase[0];
        if (w_next_phase[0]) begin
          r_shift <= {r_shift[DATA_MSB-1:DATA_LSB], adc_dout};
        end else begin
          adc_din <= w_din_next;
        end
      end
    end else if (start) begin
      r_active <= 1'b1;
      r_phase  <= 5'd0;
      r_addr   <= addr;
      adc_sck  <= 1'b0;
      adc_din  <= 1'b0;
    end
  end

  assign done   = r_active && (r_phase == c_LAST_PHASE);
  assign result = r_shift;

endmodule

`default_nettype wire

// File: rtl/lfa_adc_reader.sv
// ============================================================================
// Module   : lfa_adc_reader
// Brief    : Continuously scans the left/middle/right line-sensor channels of
//            an ADC128S022 and presents registered 12-bit readings plus a
//            one-cycle data_valid strobe after each RIGHT update.
// Config   : LFA_ADC_FILTER_EN - when defined, each output is written as
//            (new + old) >> 1; the first write after reset is unfiltered.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfa_adc_reader
  import lfa_adc_pkg::*;
#(
  parameter logic [2:0] CH_LEFT    = 3'd3,
  parameter logic [2:0] CH_MIDDLE  = 3'd2,
  parameter logic [2:0] CH_RIGHT   = 3'd1,
  parameter int         GAP_CYCLES = 2
) (
  input  logic                     clk_3125KHz,
  input  logic                     rst_n,
  input  logic                     adc_dout,
  output logic                     adc_cs_n,
  output logic                     adc_sck,
  output logic                     adc_din,
  output logic [DATA_MSB:DATA_LSB] left,
  output logic [DATA_MSB:DATA_LSB] middle,
  output logic [DATA_MSB:DATA_LSB] right,
  output logic                     data_valid
);

  localparam logic [3:0] c_GAP_LAST = 4'(GAP_CYCLES - 1);

  lfa_state_t r_state;
  logic [3:0] r_gap_cnt;
  lfa_ch_t    r_ch;
  lfa_ch_t    r_prev_ch;
  logic       r_primed;

  logic                     w_start;
  logic                     w_done;
  logic [2:0]               w_addr;
  logic [DATA_MSB:DATA_LSB] w_result;
  logic [DATA_MSB:DATA_LSB] w_wr_val;

  assign w_start = (r_state == ST_GAP) && (r_gap_cnt == c_GAP_LAST);

  // Map the logical sensor being addressed to its ADC channel code.
  always_comb begin
    w_addr = CH_RIGHT;
    case (r_ch)
      LEFT:    w_addr = CH_LEFT;
      MIDDLE:  w_addr = CH_MIDDLE;
      default: w_addr = CH_RIGHT;
    endcase
  end

  adc_spi_frame u_frame (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .start       (w_start),
    .addr        (w_addr),
    .adc_dout    (adc_dout),
    .adc_sck     (adc_sck),
    .adc_din     (adc_din),
    .done        (w_done),
    .result      (w_result)
  );

  // GAP/CONV sequencing, chip select and the one-frame-behind channel pipeline.
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_GAP;
      r_gap_cnt <= 4'd0;
      adc_cs_n  <= 1'b1;
      r_ch      <= LEFT;
      r_prev_ch <= LEFT;
      r_primed  <= 1'b0;
    end else begin
      case (r_state)
        ST_GAP: begin
          if (w_start) begin
            r_state   <= ST_CONV;
            r_gap_cnt <= 4'd0;
            adc_cs_n  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        ST_CONV: begin
          if (w_done) begin
            r_state   <= ST_GAP;
            adc_cs_n  <= 1'b1;
            r_prev_ch <= r_ch;
            r_ch      <= next_ch(r_ch);
            r_primed  <= 1'b1;
          end
        end
        default: r_state <= ST_GAP;
      endcase
    end
  end

`ifdef LFA_ADC_FILTER_EN
  logic [2:0]               r_seen;
  logic [DATA_MSB:DATA_LSB] w_old;
  logic                     w_first;
  logic [DATA_MSB+1:0]      w_sum;

  // Previous value and first-write flag of the output about to be written.
  always_comb begin
    w_old   = left;
    w_first = ~r_seen[0];
    case (r_prev_ch)
      MIDDLE: begin
        w_old   = middle;
        w_first = ~r_seen[1];
      end
      RIGHT: begin
        w_old   = right;
        w_first = ~r_seen[2];
      end
      default: begin
        w_old   = left;
        w_first = ~r_seen[0];
      end
    endcase
  end

  assign w_sum    = {1'b0, w_result} + {1'b0, w_old};
  assign w_wr_val = w_first ? w_result : w_sum[DATA_MSB+1:DATA_LSB+1];
`else
  assign w_wr_val = w_result;
`endif

  // Result of each frame lands in the output of the channel addressed one frame earlier.
  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      left       <= '0;
      middle     <= '0;
      right      <= '0;
      data_valid <= 1'b0;
`ifdef LFA_ADC_FILTER_EN
      r_seen     <= 3'b000;
`endif
    end else begin
      data_valid <= 1'b0;
      if (w_done && r_primed) begin
        case (r_prev_ch)
          LEFT:   left   <= w_wr_val;
          MIDDLE: middle <= w_wr_val;
          RIGHT: begin
            right      <= w_wr_val;
            data_valid <= 1'b1;
          end
          default: ;
        endcase
`ifdef LFA_ADC_FILTER_EN
        case (r_prev_ch)
          LEFT:    r_seen[0] <= 1'b1;
          MIDDLE:  r_seen[1] <= 1'b1;
          RIGHT:   r_seen[2] <= 1'b1;
          default: ;
        endcase
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lfa_adc_reader.sv
// ============================================================================
// Module   : tb_lfa_adc_reader
// Brief    : Self-checking bench for lfa_adc_reader with an ADC128S022 model.
//            Build with LFA_ADC_FILTER_EN defined to exercise the filter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfa_adc_reader;

  localparam int G = 2;        // GAP_CYCLES
  localparam int P = 32 + G;   // clocks per frame

`ifdef LFA_ADC_FILTER_EN
  localparam bit          c_FILT       = 1'b1;
  localparam logic [11:0] c_L0         = 12'h400;
  localparam logic [11:0] c_L1         = 12'h800;
  localparam logic [11:0] c_LEFT_FINAL = 12'h700;
`else
  localparam bit          c_FILT       = 1'b0;
  localparam logic [11:0] c_L0         = 12'h7D0;
  localparam logic [11:0] c_L1         = 12'h7D0;
  localparam logic [11:0] c_LEFT_FINAL = 12'h7D0;
`endif

  logic        clk_3125KHz = 1'b0;
  logic        rst_n       = 1'b0;
  logic        adc_dout    = 1'b0;
  logic        adc_cs_n;
  logic        adc_sck;
  logic        adc_din;
  logic [11:0] left;
  logic [11:0] middle;
  logic [11:0] right;
  logic        data_valid;

  int nchk  = 0;
  int npass = 0;
  int cyc   = 0;

  logic [11:0] e_l = '0, e_m = '0, e_r = '0;
  logic        e_dv = 1'b0;
  logic [2:0]  seen = 3'b000;
  logic [2:0]  cap_addr = 3'b000;
  logic [11:0] prev_l = '0, prev_m = '0;
  logic [2:0]  addr_q[$];
  int          dv_q[$];
  logic [11:0] lv_q[$];

  lfa_adc_reader dut (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .adc_dout    (adc_dout),
    .adc_cs_n    (adc_cs_n),
    .adc_sck     (adc_sck),
    .adc_din     (adc_din),
    .left        (left),
    .middle      (middle),
    .right       (right),
    .data_valid  (data_valid)
  );

  always #160 clk_3125KHz = ~clk_3125KHz;

  // Clocks since reset release.
  always @(posedge clk_3125KHz) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
  endtask

  // Channel addressed in frame f: LEFT(3), MIDDLE(2), RIGHT(1) repeating.
  function automatic logic [2:0] addr_of(input int f);
    case (f % 3)
      0:       return 3'd3;
      1:       return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  // Conversion value the ADC holds for channel a when it was addressed in frame f.
  function automatic logic [11:0] val_of(input logic [2:0] a, input int f);
    case (a)
      3'd3:    return (f == 0) ? c_L0 : c_L1;
      3'd2:    return 12'h0C8;
      3'd1:    return 12'hFFF;
      default: return 12'h123;
    endcase
  endfunction

  // DOUT word sent in frame f: previous frame's channel; power-up frame gives ch0.
  // Nonzero upper nibbles confirm the reader ignores bits 15:12.
  function automatic logic [15:0] word_of(input int f);
    if (f == 0) return {4'hA, 12'h123};
    return {4'h5, val_of(addr_of(f - 1), f - 1)};
  endfunction

  function automatic logic [11:0] upd(input logic [11:0] nv, input logic [11:0] old,
                                      input logic was_written);
    logic [12:0] s;
    s = {1'b0, nv} + {1'b0, old};
    if (!c_FILT || !was_written) return nv;
    return s[12:1];
  endfunction

  // ADC model plus per-cycle comparison against the frame-level model.
  always @(negedge clk_3125KHz) begin
    int t, f, p, k;
    logic [15:0] w;
    logic [2:0]  a;
    logic        e_cs, e_sck, e_din;
    if (!rst_n) begin
      e_l = '0; e_m = '0; e_r = '0; e_dv = 1'b0; seen = 3'b000;
      cap_addr = 3'b000; prev_l = '0; prev_m = '0; adc_dout = 1'b0;
    end else begin
      e_dv = 1'b0; e_cs = 1'b1; e_sck = 1'b1; p = -1; f = 0;
      if (cyc >= G) begin
        t = cyc - G;
        f = t / P;
        p = t % P;
      end
      if (p >= 0 && p < 32) begin
        e_cs  = 1'b0;
        e_sck = (p % 2) == 1;
        k     = p / 2;
        a     = addr_of(f);
        e_din = (k >= 2 && k <= 4) ? a[4 - k] : 1'b0;
        chk("din", adc_din, e_din);
        if (p % 2 == 0) begin
          w = word_of(f);
          adc_dout = w[15 - k];
        end else if (k >= 2 && k <= 4) begin
          cap_addr[4 - k] = adc_din;
        end
      end
      if (p == 32) begin
        addr_q.push_back(cap_addr);
        cap_addr = 3'b000;
        if (f >= 1) begin
          a = addr_of(f - 1);
          case (a)
            3'd3: begin e_l = upd(val_of(a, f - 1), e_l, seen[0]); seen[0] = 1'b1; end
            3'd2: begin e_m = upd(val_of(a, f - 1), e_m, seen[1]); seen[1] = 1'b1; end
            default: begin
              e_r = upd(val_of(a, f - 1), e_r, seen[2]); seen[2] = 1'b1; e_dv = 1'b1;
            end
          endcase
        end
      end
      chk("cs_n", adc_cs_n, e_cs);
      chk("sck", adc_sck, e_sck);
      chk("left", left, e_l);
      chk("middle", middle, e_m);
      chk("right", right, e_r);
      chk("data_valid", data_valid, e_dv);
      if (data_valid) begin
        dv_q.push_back(cyc);
        chk("lm_hold_on_dv", {left, middle}, {prev_l, prev_m});
      end
      if (left !== prev_l) lv_q.push_back(left);
      prev_l = left;
      prev_m = middle;
    end
  end

  initial begin
    logic [2:0] aq;
    int         dq;
    logic [11:0] lq;
    repeat (5) @(posedge clk_3125KHz);
    #20 rst_n = 1'b1;
    #1;
    chk("rst_cs_n", adc_cs_n, 1'b1);
    chk("rst_sck", adc_sck, 1'b1);
    chk("rst_din", adc_din, 1'b0);
    chk("rst_outs", {left, middle, right}, 36'h0);
    chk("rst_dv", data_valid, 1'b0);
    @(posedge clk_3125KHz); #20;
    chk("cs_high_cyc1", adc_cs_n, 1'b1);
    @(posedge clk_3125KHz); #20;
    chk("cs_fall_cyc2", adc_cs_n, 1'b0);

    // Run into the middle of frame 10 (cycle 360).
    repeat (358) @(posedge clk_3125KHz);
    #20;
    dq = dv_q.size(); chk("dv_count", dq, 3);
    dq = dv_q[0];     chk("dv_first_136", dq, 136);
    dq = dv_q[1];     chk("dv_second_238", dq, 238);
    dq = dv_q[2];     chk("dv_third_340", dq, 340);
    aq = addr_q[0];   chk("addr_f0_011", aq, 3'b011);
    aq = addr_q[1];   chk("addr_f1_010", aq, 3'b010);
    aq = addr_q[2];   chk("addr_f2_001", aq, 3'b001);
    aq = addr_q[3];   chk("addr_f3_011", aq, 3'b011);
    lq = lv_q[0];     chk("left_first_write", lq, c_L0);
`ifdef LFA_ADC_FILTER_EN
    lq = lv_q[1];     chk("left_filtered_600", lq, 12'h600);
`endif
    chk("left_final", left, c_LEFT_FINAL);
    chk("middle_final", middle, 12'h0C8);
    chk("right_final", right, 12'hFFF);

    // Reset mid-frame with live outputs: everything returns to reset values at once.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", adc_cs_n, 1'b1);
    chk("mid_rst_sck", adc_sck, 1'b1);
    chk("mid_rst_outs", {left, middle, right}, 36'h0);
    chk("mid_rst_dv", data_valid, 1'b0);
    repeat (3) @(posedge clk_3125KHz);
    #20 rst_n = 1'b1;

    // Abort the second frame at phase 17 (cycle 53).
    repeat (53) @(posedge clk_3125KHz);
    #20;
    chk("cs_low_ph17", adc_cs_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("cs_abort_ph17", adc_cs_n, 1'b1);
    dv_q.delete();
    lv_q.delete();
    repeat (3) @(posedge clk_3125KHz);
    #20 rst_n = 1'b1;

    // Re-primed pipeline: first write at cycle 68, data_valid at 136 and 238.
    repeat (250) @(posedge clk_3125KHz);
    #20;
    dq = dv_q.size(); chk("re_dv_count", dq, 2);
    dq = dv_q[0];     chk("re_dv_first_136", dq, 136);
    lq = lv_q[0];     chk("re_left_first_write", lq, c_L0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

`default_nettype wire
